trilinear_interp_pipe: RTL and testbench

Parametrised, fully pipelined trilinear interpolator for the hash-encoding datapath. It accepts one sample per cycle: 8 corner feature vectors of NUM_CH channels plus fixed-point fractional cell offsets. It returns the interpolated feature vector three cycles later. Division is removed because weights arrive pre-normalised as fractional offsets. The block adds a valid/ready handshake with backpressure, a per-sample nearest-corner mode, tag passthrough and a completed-sample counter.

---
 rtl/interp_pkg.sv | 21 ++
 rtl/trilinear_interp_pipe_if.sv | 45 ++++
 rtl/lerp_unit.sv | 54 +++++
 rtl/trilinear_interp_pipe.sv | 146 ++++++++++++++
 tb/tb_trilinear_interp_pipe.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the trilinear interpolation pipeline.
//   - Mode encodings that travel with each sample.
//   - Bit positions of x/y/z inside a corner index.
//   - Slice-offset helper for the packed corner/channel feature bus.
package interp_pkg;

    localparam logic MODE_TRILINEAR = 1'b0;
    localparam logic MODE_NEAREST   = 1'b1;

    localparam int NUM_CORNERS  = 8;
    localparam int CORNER_X_BIT = 0;
    localparam int CORNER_Y_BIT = 1;
    localparam int CORNER_Z_BIT = 2;

    // Bit offset of (corner, channel) in a bus where the channel index varies fastest.
    function automatic int feat_offset(input int corner, input int ch,
                                       input int num_ch, input int feat_w);
        return (corner * num_ch + ch) * feat_w;
    endfunction

endpackage

// File: rtl/trilinear_interp_pipe_if.sv
// Sample-in / result-out bus of the trilinear interpolator.
//
// Handshake: a transfer happens on an edge where valid & ready are both 1.
// A producer holds valid and its payload stable until the transfer happens.
// The producer may not wait for ready before it raises valid.
//
//   in_valid/in_ready  : upstream sample handshake
//   in_feat            : 8 corners x NUM_CH channels, corner-major, channel fastest
//   in_wx/in_wy/in_wz  : fractional cell offsets, value = w / 2^FRAC_W
//   in_mode            : 0 trilinear, 1 nearest corner
//   in_tag             : sideband carried to out_tag
//   out_valid/out_ready: downstream result handshake
//   out_feat/out_tag   : result vector (channel k at k*FEAT_W) and its tag
//
// master: the side that feeds samples and takes results.
// slave : the interpolator.
interface trilinear_interp_pipe_if #(
    parameter int NUM_CH = 2,
    parameter int FEAT_W = 16,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [8*NUM_CH*FEAT_W-1:0] in_feat;
    logic [FRAC_W-1:0]          in_wx;
    logic [FRAC_W-1:0]          in_wy;
    logic [FRAC_W-1:0]          in_wz;
    logic                       in_mode;
    logic [TAG_W-1:0]           in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_CH*FEAT_W-1:0]   out_feat;
    logic [TAG_W-1:0]           out_tag;

    modport master (
        output in_valid, in_feat, in_wx, in_wy, in_wz, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_feat, out_tag
    );

    modport slave (
        input  in_valid, in_feat, in_wx, in_wy, in_wz, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_feat, out_tag
    );
endinterface

// File: rtl/lerp_unit.sv
// Combinational one-dimensional interpolation between a and b.
//   a, b   : signed FEAT_W endpoints
//   w      : unsigned fractional weight, value = w / 2^FRAC_W
//   mode   : MODE_TRILINEAR -> a + round((b-a)*w), saturated
//            MODE_NEAREST   -> b when w >= 0.5, otherwise a
//   result : signed FEAT_W
module lerp_unit
    import interp_pkg::*;
#(
    parameter int FEAT_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic signed [FEAT_W-1:0] a,
    input  logic signed [FEAT_W-1:0] b,
    input  logic        [FRAC_W-1:0] w,
    input  logic                     mode,
    output logic signed [FEAT_W-1:0] result
);
    localparam int P_W = FEAT_W + FRAC_W + 2;

    localparam logic signed [P_W-1:0] HALF  = {{(P_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic signed [P_W-1:0] MAX_V = {{(P_W-FEAT_W+1){1'b0}}, {(FEAT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] MIN_V = {{(P_W-FEAT_W+1){1'b1}}, {(FEAT_W-1){1'b0}}};

    logic signed [FEAT_W:0]  d;
    logic signed [P_W-1:0]   d_ext;
    logic signed [P_W-1:0]   w_ext;
    logic signed [P_W-1:0]   a_ext;
    logic signed [P_W-1:0]   p;
    logic signed [P_W-1:0]   r;
    logic signed [P_W-1:0]   sum;

    always_comb begin
        d     = {b[FEAT_W-1], b} - {a[FEAT_W-1], a};
        d_ext = {{(P_W-FEAT_W-1){d[FEAT_W]}}, d};
        w_ext = {{(P_W-FRAC_W){1'b0}}, w};
        a_ext = {{(P_W-FEAT_W){a[FEAT_W-1]}}, a};
        // |d| <= 2^FEAT_W and w < 2^FRAC_W, so the product fits in P_W bits.
        p     = d_ext * w_ext;
        // Round half up, then floor via arithmetic shift (also for negative p).
        r     = (p + HALF) >>> FRAC_W;
        sum   = a_ext + r;

        if (mode == MODE_NEAREST) begin
            result = w[FRAC_W-1] ? b : a;
        end else if (sum > MAX_V) begin
            result = MAX_V[FEAT_W-1:0];
        end else if (sum < MIN_V) begin
            result = MIN_V[FEAT_W-1:0];
        end else begin
            result = sum[FEAT_W-1:0];
        end
    end
endmodule

// File: rtl/trilinear_interp_pipe.sv
// Three-stage trilinear interpolator: S1 lerps along x, S2 along y, S3 along z.
// One sample per cycle; a result appears three cycles after acceptance.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : sample/result handshake bus (slave side)
//   done_cnt  : number of results accepted downstream, wraps
// Any stage holds when the output is valid but not taken; the whole pipe
// stalls together, so nothing is dropped or duplicated.
module trilinear_interp_pipe
    import interp_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int FEAT_W = 16,
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    trilinear_interp_pipe_if.slave bus,
    output logic [CNT_W-1:0]     done_cnt
);
    logic stall;

    // Stage 1 registers
    logic                     s1_valid;
    logic signed [FEAT_W-1:0] s1_feat [NUM_CH][4];
    logic [FRAC_W-1:0]        s1_wy;
    logic [FRAC_W-1:0]        s1_wz;
    logic                     s1_mode;
    logic [TAG_W-1:0]         s1_tag;

    // Stage 2 registers
    logic                     s2_valid;
    logic signed [FEAT_W-1:0] s2_feat [NUM_CH][2];
    logic [FRAC_W-1:0]        s2_wz;
    logic                     s2_mode;
    logic [TAG_W-1:0]         s2_tag;

    // Stage 3 registers drive the output bus directly
    logic                     out_valid_q;
    logic [NUM_CH*FEAT_W-1:0] out_feat_q;
    logic [TAG_W-1:0]         out_tag_q;

    // Combinational lerp results feeding each stage register
    logic signed [FEAT_W-1:0] x_res [NUM_CH][4];
    logic signed [FEAT_W-1:0] y_res [NUM_CH][2];
    logic signed [FEAT_W-1:0] z_res [NUM_CH];

    assign stall         = out_valid_q & ~bus.out_ready;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_feat  = out_feat_q;
    assign bus.out_tag   = out_tag_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // Pair index q is the corner's {z,y} bits; the pair differs only in x.
        for (genvar q = 0; q < 4; q++) begin : g_x
            localparam int C_LO = q << 1;
            localparam int C_HI = C_LO | (1 << CORNER_X_BIT);
            lerp_unit #(.FEAT_W(FEAT_W), .FRAC_W(FRAC_W)) u_x (
                .a      (bus.in_feat[feat_offset(C_LO, ch, NUM_CH, FEAT_W) +: FEAT_W]),
                .b      (bus.in_feat[feat_offset(C_HI, ch, NUM_CH, FEAT_W) +: FEAT_W]),
                .w      (bus.in_wx),
                .mode   (bus.in_mode),
                .result (x_res[ch][q])
            );
        end
        for (genvar q = 0; q < 2; q++) begin : g_y
            lerp_unit #(.FEAT_W(FEAT_W), .FRAC_W(FRAC_W)) u_y (
                .a      (s1_feat[ch][2*q]),
                .b      (s1_feat[ch][2*q+1]),
                .w      (s1_wy),
                .mode   (s1_mode),
                .result (y_res[ch][q])
            );
        end
        lerp_unit #(.FEAT_W(FEAT_W), .FRAC_W(FRAC_W)) u_z (
            .a      (s2_feat[ch][0]),
            .b      (s2_feat[ch][1]),
            .w      (s2_wz),
            .mode   (s2_mode),
            .result (z_res[ch])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid    <= 1'b0;
            s1_feat     <= '{default: '0};
            s1_wy       <= '0;
            s1_wz       <= '0;
            s1_mode     <= MODE_TRILINEAR;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_feat     <= '{default: '0};
            s2_wz       <= '0;
            s2_mode     <= MODE_TRILINEAR;
            s2_tag      <= '0;
            out_valid_q <= 1'b0;
            out_feat_q  <= '0;
            out_tag_q   <= '0;
        end else if (!stall) begin
            // Not stalled means in_ready is 1, so in_valid alone marks a transfer.
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int q = 0; q < 4; q++) begin
                        s1_feat[ch][q] <= x_res[ch][q];
                    end
                end
                s1_wy   <= bus.in_wy;
                s1_wz   <= bus.in_wz;
                s1_mode <= bus.in_mode;
                s1_tag  <= bus.in_tag;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int q = 0; q < 2; q++) begin
                        s2_feat[ch][q] <= y_res[ch][q];
                    end
                end
                s2_wz   <= s1_wz;
                s2_mode <= s1_mode;
                s2_tag  <= s1_tag;
            end

            out_valid_q <= s2_valid;
            if (s2_valid) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    out_feat_q[ch*FEAT_W +: FEAT_W] <= z_res[ch];
                end
                out_tag_q <= s2_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_trilinear_interp_pipe.sv
module tb_trilinear_interp_pipe;
    localparam int NUM_CH = 2;
    localparam int FEAT_W = 16;
    localparam int FRAC_W = 8;
    localparam int TAG_W  = 8;
    localparam int CNT_W  = 32;

    typedef struct {
        int         c0 [8];
        int         c1 [8];
        logic [7:0] wx;
        logic [7:0] wy;
        logic [7:0] wz;
        logic       mode;
        int         e0;
        int         e1;
    } vec_t;

    logic             clk;
    logic             rstn;
    logic [CNT_W-1:0] done_cnt;

    trilinear_interp_pipe_if #(
        .NUM_CH(NUM_CH), .FEAT_W(FEAT_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)
    ) bus ();

    trilinear_interp_pipe #(
        .NUM_CH(NUM_CH), .FEAT_W(FEAT_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int         tests_run = 0;
    int         tests_failed = 0;
    int         exp_cnt = 0;
    logic [7:0] exp_q [$];
    vec_t       vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_ch(input int ch);
        logic signed [FEAT_W-1:0] v;
        v = bus.out_feat[ch*FEAT_W +: FEAT_W];
        return int'(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_vec(input vec_t v, input logic [7:0] tag);
        for (int c = 0; c < 8; c++) begin
            bus.in_feat[(c*NUM_CH+0)*FEAT_W +: FEAT_W] = 16'(v.c0[c]);
            bus.in_feat[(c*NUM_CH+1)*FEAT_W +: FEAT_W] = 16'(v.c1[c]);
        end
        bus.in_wx    = v.wx;
        bus.in_wy    = v.wy;
        bus.in_wz    = v.wz;
        bus.in_mode  = v.mode;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
    endtask

    task automatic drive_const(input int val0, input int val1, input logic [7:0] tag);
        for (int c = 0; c < 8; c++) begin
            bus.in_feat[(c*NUM_CH+0)*FEAT_W +: FEAT_W] = 16'(val0);
            bus.in_feat[(c*NUM_CH+1)*FEAT_W +: FEAT_W] = 16'(val1);
        end
        bus.in_wx    = 8'd77;
        bus.in_wy    = 8'd200;
        bus.in_wz    = 8'd13;
        bus.in_mode  = 1'b0;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
    endtask

    // One sample with out_ready held high: checks exact 3-cycle latency and a one-cycle pulse.
    task automatic run_single(input vec_t v, input logic [7:0] tag, input string name);
        @(negedge clk);
        bus.out_ready = 1'b1;
        drive_vec(v, tag);
        #1;
        check({name, " in_ready"}, longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, " early_valid"}, longint'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        check({name, " out_valid"}, longint'(bus.out_valid), 1);
        check({name, " ch0"}, out_ch(0), v.e0);
        check({name, " ch1"}, out_ch(1), v.e1);
        check({name, " tag"}, longint'(bus.out_tag), longint'(tag));
        exp_cnt++;
        @(posedge clk);
        #1;
        check({name, " pulse_end"}, longint'(bus.out_valid), 0);
        check({name, " done_cnt"}, longint'(done_cnt), exp_cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int next_tag;
        int got;
        logic fire_in;
        logic fire_out;
        logic [7:0] exp_tag;
        logic saw_valid;

        // Ramp along the corner index; channel 1 alternates -256 (x=0) / -512 (x=1).
        vecs[0] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd128, wy: 8'd128, wz: 8'd128, mode: 1'b0, e0: 896, e1: -384};
        vecs[1] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd0, wy: 8'd0, wz: 8'd0, mode: 1'b0, e0: 0, e1: -256};
        vecs[2] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd255, wy: 8'd0, wz: 8'd0, mode: 1'b0, e0: 255, e1: -511};
        vecs[3] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd128, wy: 8'd127, wz: 8'd200, mode: 1'b1, e0: 1280, e1: -512};
        // Full-scale swings along x in both directions.
        vecs[4] = '{c0: '{-32768, 32767, -32768, 32767, -32768, 32767, -32768, 32767},
                    c1: '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768},
                    wx: 8'd255, wy: 8'd0, wz: 8'd0, mode: 1'b0, e0: 32511, e1: -32512};
        vecs[5] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd64, wy: 8'd64, wz: 8'd64, mode: 1'b0, e0: 448, e1: -320};
        vecs[6] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd255, wy: 8'd255, wz: 8'd255, mode: 1'b1, e0: 1792, e1: -512};
        vecs[7] = '{c0: '{0, 256, 512, 768, 1024, 1280, 1536, 1792},
                    c1: '{-256, -512, -256, -512, -256, -512, -256, -512},
                    wx: 8'd127, wy: 8'd127, wz: 8'd127, mode: 1'b1, e0: 0, e1: -256};

        // ---------------- reset block ----------------
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_feat  = '0;
        bus.in_wx    = '0;
        bus.in_wy    = '0;
        bus.in_wz    = '0;
        bus.in_mode  = 1'b0;
        bus.in_tag   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", longint'(bus.out_valid), 0);
        check("rst out_feat", longint'(bus.out_feat), 0);
        check("rst out_tag", longint'(bus.out_tag), 0);
        check("rst done_cnt", longint'(done_cnt), 0);
        check("rst in_ready", longint'(bus.in_ready), 1);
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i], 8'(8'hA0 + i), $sformatf("vec%0d", i));
        end

        // ---------------- backpressure stream ----------------
        next_tag = 0;
        got = 0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc >= 4 && cyc <= 7);
            if (next_tag < 10) drive_const(next_tag * 100, -next_tag, 8'(next_tag));
            else               bus.in_valid = 1'b0;
            #1;
            check($sformatf("bp in_ready c%0d", cyc), longint'(bus.in_ready),
                  (cyc >= 4 && cyc <= 7) ? 0 : 1);
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check("bp unexpected_out", longint'(bus.out_tag), -1);
                end else begin
                    exp_tag = exp_q.pop_front();
                    check("bp tag", longint'(bus.out_tag), longint'(exp_tag));
                    check("bp ch0", out_ch(0), int'(exp_tag) * 100);
                    check("bp ch1", out_ch(1), -int'(exp_tag));
                end
                got++;
            end
            if (fire_in) exp_q.push_back(8'(next_tag));
            @(posedge clk);
            if (fire_in)  next_tag++;
            if (fire_out) exp_cnt++;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp received", got, 10);
        check("bp queue_empty", exp_q.size(), 0);
        check("bp no_extra", longint'(bus.out_valid), 0);
        check("bp done_cnt", longint'(done_cnt), exp_cnt);

        // ---------------- reset with samples in flight ----------------
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_vec(vecs[0], 8'(8'h50 + k));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midrst out_valid", longint'(bus.out_valid), 0);
        check("midrst done_cnt", longint'(done_cnt), 0);
        check("midrst out_tag", longint'(bus.out_tag), 0);
        exp_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        saw_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) saw_valid = 1'b1;
        end
        check("midrst leftover", longint'(saw_valid), 0);
        run_single(vecs[0], 8'h77, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
